ysyx_23060240_mem_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one request at a time from either master, forwards it downstream through a request/response handshake, and routes the response back to the owner. It arbitrates round-robin on contention and converts a missing downstream response into an error response after a bounded wait. It sits between the IFU/LSU and the memory/bus interface.

---
 rtl/ysyx_23060240_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ysyx_23060240_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with round-robin grant and
// a bounded response wait that turns a missing response into an error strobe.
module ysyx_23060240_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [15:0] cnt_q, cnt_d;

    logic ifu_win, lsu_win, ifu_acc, lsu_acc, timed_out, resp_fire;

    // On contention the master that did not win last time gets the grant.
    assign ifu_win   = ifu_req_valid && (!lsu_req_valid || last_q == OWN_LSU);
    assign lsu_win   = lsu_req_valid && (!ifu_req_valid || last_q == OWN_IFU);
    assign ifu_acc   = ifu_req_valid && ifu_req_ready;
    assign lsu_acc   = lsu_req_valid && lsu_req_ready;
    assign timed_out = (cnt_q == TO_LAST);
    assign resp_fire = mem_resp_valid || timed_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ifu_acc || lsu_acc) state_d = S_REQ;
            S_REQ:   if (mem_req_ready)      state_d = S_WAIT;
            S_WAIT:  if (resp_fire)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = 32'h0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = 32'h0;
        lsu_resp_err   = 1'b0;
        mem_req_valid  = 1'b0;
        mem_addr       = 32'h0;
        mem_wen        = 1'b0;
        mem_wdata      = 32'h0;
        mem_wmask      = 4'h0;
        unique case (state_q)
            S_IDLE: begin
                ifu_req_ready = rst && ifu_win;
                lsu_req_ready = rst && lsu_win;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = addr_q;
                mem_wen       = wen_q;
                mem_wdata     = wdata_q;
                mem_wmask     = wmask_q;
            end
            S_WAIT: begin
                // A real response beats a coincident timeout.
                if (owner_q == OWN_IFU) begin
                    ifu_resp_valid = resp_fire;
                    ifu_rdata      = mem_resp_valid ? mem_rdata : 32'h0;
                    ifu_resp_err   = !mem_resp_valid && timed_out;
                end else begin
                    lsu_resp_valid = resp_fire;
                    lsu_rdata      = mem_resp_valid ? mem_rdata : 32'h0;
                    lsu_resp_err   = !mem_resp_valid && timed_out;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        cnt_d   = cnt_q;
        if (ifu_acc) begin
            owner_d = OWN_IFU;
            last_d  = OWN_IFU;
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = 32'h0;
            wmask_d = 4'h0;
        end else if (lsu_acc) begin
            owner_d = OWN_LSU;
            last_d  = OWN_LSU;
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
        end
        if (state_q == S_REQ && mem_req_ready) cnt_d = 16'h0;
        else if (state_q == S_WAIT)            cnt_d = cnt_q + 16'h1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            cnt_q   <= 16'h0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (TIMEOUT=4 instance).
module tb_ysyx_23060240_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = 32'h0;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0;
    logic        lsu_wen = 1'b0;
    logic [3:0]  lsu_wmask = 4'h0;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_wen;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_chk = 0;
    int n_fail = 0;

    ysyx_23060240_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (well before next edge).
    task automatic settle();
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ifu_rdy"}, {31'h0, ifu_req_ready}, 32'h0);
        chk({tag, " lsu_rdy"}, {31'h0, lsu_req_ready}, 32'h0);
        chk({tag, " ifu_rv"},  {31'h0, ifu_resp_valid}, 32'h0);
        chk({tag, " ifu_rd"},  ifu_rdata, 32'h0);
        chk({tag, " lsu_rv"},  {31'h0, lsu_resp_valid}, 32'h0);
        chk({tag, " lsu_rd"},  lsu_rdata, 32'h0);
        chk({tag, " mvalid"},  {31'h0, mem_req_valid}, 32'h0);
        chk({tag, " maddr"},   mem_addr, 32'h0);
    endtask

    initial begin
        // Reset: outputs zero even with requests and a response present.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #12;
        chk_all_zero("reset");
        lsu_req_valid = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;

        // IFU-only read, fastest path.
        step();
        rst = 1'b1;
        ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        settle();
        chk("t1 ifu_rdy N", {31'h0, ifu_req_ready}, 32'h1);
        chk("t1 lsu_rdy N", {31'h0, lsu_req_ready}, 32'h0);
        step();
        ifu_req_valid = 1'b0;
        settle();
        chk("t1 mvalid N+1", {31'h0, mem_req_valid}, 32'h1);
        chk("t1 maddr N+1", mem_addr, 32'h8000_0000);
        chk("t1 mwen N+1", {31'h0, mem_wen}, 32'h0);
        chk("t1 ifu_rdy N+1", {31'h0, ifu_req_ready}, 32'h0);
        step();
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        settle();
        chk("t1 ifu_rv N+2", {31'h0, ifu_resp_valid}, 32'h1);
        chk("t1 ifu_rd N+2", ifu_rdata, 32'h0000_0413);
        chk("t1 ifu_err N+2", {31'h0, ifu_resp_err}, 32'h0);
        chk("t1 lsu_rv N+2", {31'h0, lsu_resp_valid}, 32'h0);
        step();
        mem_resp_valid = 1'b0;
        settle();
        chk("t1 ifu_rv N+3", {31'h0, ifu_resp_valid}, 32'h0);
        chk("t1 ifu_rd N+3", ifu_rdata, 32'h0);

        // Reset pulse, then both masters valid continuously: IFU, LSU, IFU, LSU.
        rst = 1'b0;
        step();
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        for (int t = 0; t < 4; t++) begin
            automatic logic is_ifu = (t % 2 == 0);
            settle();
            chk($sformatf("t2[%0d] ifu_rdy", t), {31'h0, ifu_req_ready}, {31'h0, is_ifu});
            chk($sformatf("t2[%0d] lsu_rdy", t), {31'h0, lsu_req_ready}, {31'h0, !is_ifu});
            chk($sformatf("t2[%0d] idle resp", t), {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
            step();
            settle();
            chk($sformatf("t2[%0d] maddr", t), mem_addr, is_ifu ? 32'h8000_0040 : 32'h8000_1000);
            chk($sformatf("t2[%0d] mwen", t), {31'h0, mem_wen}, {31'h0, !is_ifu});
            chk($sformatf("t2[%0d] mwdata", t), mem_wdata, is_ifu ? 32'h0 : 32'hDEAD_BEEF);
            chk($sformatf("t2[%0d] mwmask", t), {28'h0, mem_wmask}, is_ifu ? 32'h0 : 32'hF);
            chk($sformatf("t2[%0d] req resp", t), {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
            step();
            settle();
            chk($sformatf("t2[%0d] ifu_rv", t), {31'h0, ifu_resp_valid}, {31'h0, is_ifu});
            chk($sformatf("t2[%0d] lsu_rv", t), {31'h0, lsu_resp_valid}, {31'h0, !is_ifu});
            chk($sformatf("t2[%0d] rdata", t), is_ifu ? ifu_rdata : lsu_rdata, 32'hA5A5_5A5A);
            step();
        end

        // LSU read with downstream stalled 5 cycles; IFU kept requesting.
        ifu_req_valid = 1'b0;
        lsu_wen = 1'b0; lsu_addr = 32'h8000_2000; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        settle();
        chk("t3 lsu_rdy", {31'h0, lsu_req_ready}, 32'h1);
        for (int c = 0; c < 6; c++) begin
            step();
            ifu_req_valid = 1'b1;
            lsu_addr = 32'h1111_0000;
            if (c == 5) mem_req_ready = 1'b1;
            settle();
            chk($sformatf("t3[%0d] mvalid", c), {31'h0, mem_req_valid}, 32'h1);
            chk($sformatf("t3[%0d] maddr", c), mem_addr, 32'h8000_2000);
            chk($sformatf("t3[%0d] rdy", c), {30'h0, ifu_req_ready, lsu_req_ready}, 32'h0);
        end

        // No response: timeout error in the 4th WAIT cycle, then IFU granted.
        for (int w = 1; w <= 4; w++) begin
            step();
            mem_req_ready = 1'b0;
            settle();
            chk($sformatf("t4 w%0d mvalid", w), {31'h0, mem_req_valid}, 32'h0);
            chk($sformatf("t4 w%0d lsu_rv", w), {31'h0, lsu_resp_valid}, {31'h0, w == 4});
            chk($sformatf("t4 w%0d lsu_err", w), {31'h0, lsu_resp_err}, {31'h0, w == 4});
            chk($sformatf("t4 w%0d lsu_rd", w), lsu_rdata, 32'h0);
            chk($sformatf("t4 w%0d ifu_rv", w), {31'h0, ifu_resp_valid}, 32'h0);
        end
        step();
        ifu_addr = 32'h8000_3000; mem_req_ready = 1'b1;
        settle();
        chk("t4 next ifu_rdy", {31'h0, ifu_req_ready}, 32'h1);
        chk("t4 next lsu_rdy", {31'h0, lsu_req_ready}, 32'h0);

        // Response coincides with timeout: real response wins.
        step();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        settle();
        chk("t5 maddr", mem_addr, 32'h8000_3000);
        for (int w = 1; w <= 4; w++) begin
            step();
            mem_req_ready = 1'b0;
            if (w == 4) begin mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; end
            settle();
            chk($sformatf("t5 w%0d ifu_rv", w), {31'h0, ifu_resp_valid}, {31'h0, w == 4});
            chk($sformatf("t5 w%0d ifu_err", w), {31'h0, ifu_resp_err}, 32'h0);
            chk($sformatf("t5 w%0d ifu_rd", w), ifu_rdata, (w == 4) ? 32'h1234_5678 : 32'h0);
        end

        // Reset during WAIT abandons the LSU transaction.
        step();
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; mem_req_ready = 1'b1;
        settle();
        chk("t6 lsu_rdy", {31'h0, lsu_req_ready}, 32'h1);
        step();
        lsu_req_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        settle();
        chk("t6 wait lsu_rv", {31'h0, lsu_resp_valid}, 32'h0);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_addr = 32'h8000_5000;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0055;
        rst = 1'b0;
        #1;
        chk_all_zero("t6 rst");
        step();
        rst = 1'b1;
        settle();
        chk("t6 rel ifu_rdy", {31'h0, ifu_req_ready}, 32'h1);
        chk("t6 rel lsu_rdy", {31'h0, lsu_req_ready}, 32'h0);
        chk("t6 rel lsu_rv", {31'h0, lsu_resp_valid}, 32'h0);
        step();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        settle();
        chk("t6 req maddr", mem_addr, 32'h8000_5000);
        chk("t6 req stale", {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
